mem_arbiter: RTL

- Shares one single-port memory2c instance between the fetch stage (read-only requester) and the memory stage (read/write requester).
- Sequences each access through a fixed-latency issue/capture/acknowledge FSM.
- Data requests have priority. A streak limit guarantees that fetch cannot be starved.
- Requesters stall their pipeline stage until they see their ack pulse.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arbiter_if.sv | 37 +++
 rtl/arb_streak_ctr.sv | 40 ++++
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared state/owner encodings and default sizing for the shared memory-port arbiters.
package mem_arb_pkg;

    localparam int unsigned LAT_DEF        = 1;
    localparam int unsigned MAX_STREAK_DEF = 4;
    localparam int unsigned CNT_W          = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/ack bundle for the fetch and data requesters plus the shared memory port.
interface mem_arbiter_if #(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 16
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ack;
    logic [DW-1:0] if_rdata;

    logic          dm_req;
    logic          dm_wr;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_ack;
    logic [DW-1:0] dm_rdata;

    logic          mem_en;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          busy;

    modport slave (
        input  if_req, if_addr, dm_req, dm_wr, dm_addr, dm_wdata, mem_rdata,
        output if_ack, if_rdata, dm_ack, dm_rdata,
               mem_en, mem_wr, mem_addr, mem_wdata, busy
    );

    modport master (
        output if_req, if_addr, dm_req, dm_wr, dm_addr, dm_wdata, mem_rdata,
        input  if_ack, if_rdata, dm_ack, dm_rdata,
               mem_en, mem_wr, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/arb_streak_ctr.sv
// Saturating 4-bit streak counter; sat_o is high once MAX consecutive increments have accrued.
module arb_streak_ctr
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX = MAX_STREAK_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  logic clr_i,
    output logic sat_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;

    // clr wins over inc; sat is registered alongside the count it describes
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CNT_W'(MAX))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        sat_d = (cnt_d == CNT_W'(MAX));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sat_q <= sat_d;
        end
    end

    assign sat_o = sat_q;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between fetch (read-only) and data (read/write) requesters
// through a fixed-latency IDLE/ACCESS/RESP sequence; data has priority, bounded by a streak limit.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned LAT        = LAT_DEF,
    parameter int unsigned MAX_STREAK = MAX_STREAK_DEF,
    parameter int unsigned AW         = 16,
    parameter int unsigned DW         = 16
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    owner_e           owner_q, owner_d;
    logic             wr_q, wr_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic [DW-1:0]    rdata_q, rdata_d;

    logic             mem_en_q, mem_en_d;
    logic             mem_wr_q, mem_wr_d;
    logic [AW-1:0]    mem_addr_q, mem_addr_d;
    logic [DW-1:0]    mem_wdata_q, mem_wdata_d;
    logic             if_ack_q, if_ack_d;
    logic [DW-1:0]    if_rdata_q, if_rdata_d;
    logic             dm_ack_q, dm_ack_d;
    logic [DW-1:0]    dm_rdata_q, dm_rdata_d;
    logic             busy_q, busy_d;

    logic             streak_inc, streak_clr, streak_sat;

    arb_streak_ctr #(
        .MAX   (MAX_STREAK)
    ) u_streak (
        .clk   (clk),
        .rst   (rst),
        .inc_i (streak_inc),
        .clr_i (streak_clr),
        .sat_o (streak_sat)
    );

    // Next-state, latch updates and next values of the registered outputs
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        owner_d    = owner_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        streak_inc = 1'b0;
        streak_clr = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.dm_req && !(bus.if_req && streak_sat)) begin
                    state_d    = ACCESS;
                    count_d    = '0;
                    owner_d    = OWN_DM;
                    wr_d       = bus.dm_wr;
                    addr_d     = bus.dm_addr;
                    wdata_d    = bus.dm_wdata;
                    streak_inc = bus.if_req;
                    streak_clr = !bus.if_req;
                end else if (bus.if_req) begin
                    state_d    = ACCESS;
                    count_d    = '0;
                    owner_d    = OWN_IF;
                    wr_d       = 1'b0;
                    addr_d     = bus.if_addr;
                    wdata_d    = '0;
                    streak_clr = 1'b1;
                end
            end
            ACCESS: begin
                count_d = count_q + CNT_W'(1);
                if (count_q == CNT_W'(LAT - 1)) begin
                    rdata_d = wr_q ? '0 : bus.mem_rdata;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are computed from next-state so they register in step with the FSM
        mem_en_d    = (state_d == ACCESS);
        mem_wr_d    = mem_en_d && wr_d;
        mem_addr_d  = mem_en_d ? addr_d : '0;
        mem_wdata_d = mem_en_d ? wdata_d : '0;
        if_ack_d    = (state_d == RESP) && (owner_d == OWN_IF);
        dm_ack_d    = (state_d == RESP) && (owner_d == OWN_DM);
        if_rdata_d  = if_ack_d ? rdata_d : '0;
        dm_rdata_d  = dm_ack_d ? rdata_d : '0;
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            owner_q     <= OWN_IF;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            mem_en_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            if_rdata_q  <= '0;
            dm_ack_q    <= 1'b0;
            dm_rdata_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            owner_q     <= owner_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            mem_en_q    <= mem_en_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ack_q    <= if_ack_d;
            if_rdata_q  <= if_rdata_d;
            dm_ack_q    <= dm_ack_d;
            dm_rdata_q  <= dm_rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_ack    = dm_ack_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.busy      = busy_q;

endmodule
